// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the RV32I multi-cycle control sequencer:
// state encoding, opcode, ALU-op and funct3 constants.
// Optional feature macro: ILLEGAL_TRAP_EN (adds the TRAP state).
package rv_ctrl_pkg;

  // Sequencer phases. TRAP only exists when illegal-opcode trapping is built in.
  typedef enum logic [3:0] {
    ST_FETCH = 4'd0,
    ST_DECODE,
    ST_EXEC_ALU,
    ST_EXEC_ADDR,
    ST_EXEC_BR,
    ST_MEM,
    ST_WB_ALU,
`ifdef ILLEGAL_TRAP_EN
    ST_WB_LOAD,
    ST_TRAP
`else
    ST_WB_LOAD
`endif
  } state_e;

  // Supported major opcodes (instruction bits [6:0]).
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU operation select driven to the ALU control decoder.
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // Branch conditions understood by the sequencer.
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/multicycle_ctrl_fsm_instret_counter.sv
// Retired-instruction counter: synchronous clear, increment enable,
// wraps modulo 2^W.
module instret_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: plain wrap-around increment, no saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + W'(1);
  end

  // Count register; clear wins over increment.
  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core. Steps the shared ALU,
// register file and unified memory port through fetch / decode / execute /
// memory / write-back, stalls on mem_ready and counts retired instructions.
// Optional feature macro: ILLEGAL_TRAP_EN -- unsupported opcodes park the
// sequencer in TRAP with illegal_instr high until reset. Without it they
// are dropped as uncounted NOPs.
module multicycle_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_branch,
  output logic                 ir_write,
  output logic                 addr_sel,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [1:0]           alu_op,
  output logic                 alu_src,
  output logic                 reg_write,
  output logic                 mem_to_reg,
`ifdef ILLEGAL_TRAP_EN
  output logic                 illegal_instr,
`endif
  output logic [INSTRET_W-1:0] instret
);

  state_e     state_q, state_d;
  logic [6:0] op_q, op_d;
  logic [2:0] f3_q, f3_d;
  logic       retire;

  // Next-state, decode latch and control decode. Outputs are Moore except
  // the FETCH/MEM completion pulses, which need mem_ready.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    f3_d       = f3_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    pc_branch  = 1'b0;
    ir_write   = 1'b0;
    addr_sel   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = ALUOP_ADD;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_instr = 1'b0;
`endif
    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      // Only this state looks at the live IR fields; later phases use the
      // latched copies so the IR may change underneath them.
      ST_DECODE: begin
        op_d = opcode;
        f3_d = funct3;
        case (opcode)
          OP_R, OP_I:         state_d = ST_EXEC_ALU;
          OP_LOAD, OP_STORE:  state_d = ST_EXEC_ADDR;
          OP_BRANCH:          state_d = ST_EXEC_BR;
`ifdef ILLEGAL_TRAP_EN
          default:            state_d = ST_TRAP;
`else
          default:            state_d = ST_FETCH;
`endif
        endcase
      end
      ST_EXEC_ALU: begin
        if (op_q == OP_I) begin
          alu_op  = ALUOP_I;
          alu_src = 1'b1;
        end else begin
          alu_op  = ALUOP_R;
          alu_src = 1'b0;
        end
        state_d = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_EXEC_ADDR: begin
        alu_op  = ALUOP_ADD;
        alu_src = 1'b1;
        state_d = ST_MEM;
      end
      // Request held until the ready cycle; a store retires right here.
      ST_MEM: begin
        addr_sel = 1'b1;
        if (op_q == OP_STORE) mem_write = 1'b1;
        else                  mem_read  = 1'b1;
        if (mem_ready) begin
          if (op_q == OP_STORE) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB_LOAD;
          end
        end
      end
      ST_WB_LOAD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      // Branch resolves in one cycle from the ALU zero flag; unknown
      // funct3 values simply fall through without redirecting.
      ST_EXEC_BR: begin
        alu_op  = ALUOP_SUB;
        alu_src = 1'b0;
        case (f3_q)
          F3_BEQ:  pc_branch = zero;
          F3_BNE:  pc_branch = ~zero;
          default: pc_branch = 1'b0;
        endcase
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP: begin
        illegal_instr = 1'b1;
      end
`endif
      default: state_d = ST_FETCH;
    endcase

    // Reset aborts whatever is in flight: no enables, no retire.
    if (rst) begin
      retire     = 1'b0;
      pc_write   = 1'b0;
      pc_branch  = 1'b0;
      ir_write   = 1'b0;
      addr_sel   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_op     = ALUOP_ADD;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_instr = 1'b0;
`endif
    end
  end

  // State and latched IR fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      f3_q    <= f3_d;
    end
  end

  instret_counter #(.W(INSTRET_W)) u_instret (
    .clk (clk),
    .clr (rst),
    .inc (retire),
    .cnt (instret)
  );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. Two instances share stimulus:
// a 32-bit counter build and a 4-bit one to exercise instret wrap.
`timescale 1ns/1ps
module tb_multicycle_ctrl_fsm;
  import rv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic pc_write, pc_branch, ir_write, addr_sel, mem_read, mem_write;
  logic alu_src, reg_write, mem_to_reg;
  logic [1:0]  alu_op;
  logic [31:0] instret;

  logic pc_write_s, pc_branch_s, ir_write_s, addr_sel_s, mem_read_s, mem_write_s;
  logic alu_src_s, reg_write_s, mem_to_reg_s;
  logic [1:0] alu_op_s;
  logic [3:0] instret_s;
`ifdef ILLEGAL_TRAP_EN
  logic illegal, illegal_s;
`endif

  logic [10:0] cw_a, cw_b;
  assign cw_a = {pc_write, pc_branch, ir_write, addr_sel, mem_read, mem_write,
                 alu_op, alu_src, reg_write, mem_to_reg};
  assign cw_b = {pc_write_s, pc_branch_s, ir_write_s, addr_sel_s, mem_read_s, mem_write_s,
                 alu_op_s, alu_src_s, reg_write_s, mem_to_reg_s};

  int n_cmp  = 0;
  int n_fail = 0;
  int cnt    = 0;   // reference retired count

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.INSTRET_W(32)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_branch(pc_branch),
    .ir_write(ir_write), .addr_sel(addr_sel), .mem_read(mem_read),
    .mem_write(mem_write), .alu_op(alu_op), .alu_src(alu_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg),
`ifdef ILLEGAL_TRAP_EN
    .illegal_instr(illegal),
`endif
    .instret(instret)
  );

  multicycle_ctrl_fsm #(.INSTRET_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write_s), .pc_branch(pc_branch_s),
    .ir_write(ir_write_s), .addr_sel(addr_sel_s), .mem_read(mem_read_s),
    .mem_write(mem_write_s), .alu_op(alu_op_s), .alu_src(alu_src_s),
    .reg_write(reg_write_s), .mem_to_reg(mem_to_reg_s),
`ifdef ILLEGAL_TRAP_EN
    .illegal_instr(illegal_s),
`endif
    .instret(instret_s)
  );

  // Control word in the same bit order as cw_a/cw_b.
  function automatic logic [10:0] cw(bit pcw, bit pcb, bit irw, bit asel, bit mr,
                                     bit mw, logic [1:0] aop, bit asrc, bit rw, bit m2r);
    return {pcw, pcb, irw, asel, mr, mw, aop, asrc, rw, m2r};
  endfunction

  // Runs one instruction. The expected per-cycle control words are listed
  // from the instruction class; mem_ready follows rq (0, 1, or 2 = random,
  // i.e. a cycle where mem_ready must not matter). IR fields are only held
  // valid in the decode cycle. abort_at >= 0 pulses rst in that cycle.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input bit z, input int fw, input int mw, input int abort_at);
    logic [10:0] ew[$];
    int          rq[$];
    logic [10:0] exp_w;
    bit          ret;
    bit          ld;
    int          dec_idx;
    bit          pcb;
    ret = 1'b0;
    ld  = (op == OP_LOAD);
    for (int i = 0; i < fw; i++) begin
      ew.push_back(cw(0,0,0,0,1,0,2'b00,0,0,0)); rq.push_back(0);
    end
    ew.push_back(cw(1,0,1,0,1,0,2'b00,0,0,0)); rq.push_back(1);
    dec_idx = ew.size();
    ew.push_back(11'd0); rq.push_back(2);
    case (op)
      OP_R: begin
        ew.push_back(cw(0,0,0,0,0,0,2'b10,0,0,0)); rq.push_back(2);
        ew.push_back(cw(0,0,0,0,0,0,2'b00,0,1,0)); rq.push_back(2);
        ret = 1'b1;
      end
      OP_I: begin
        ew.push_back(cw(0,0,0,0,0,0,2'b11,1,0,0)); rq.push_back(2);
        ew.push_back(cw(0,0,0,0,0,0,2'b00,0,1,0)); rq.push_back(2);
        ret = 1'b1;
      end
      OP_LOAD, OP_STORE: begin
        ew.push_back(cw(0,0,0,0,0,0,2'b00,1,0,0)); rq.push_back(2);
        for (int i = 0; i <= mw; i++) begin
          ew.push_back(cw(0,0,0,1,ld,!ld,2'b00,0,0,0)); rq.push_back(i == mw ? 1 : 0);
        end
        if (ld) begin
          ew.push_back(cw(0,0,0,0,0,0,2'b00,0,1,1)); rq.push_back(2);
        end
        ret = 1'b1;
      end
      OP_BRANCH: begin
        pcb = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
        ew.push_back(cw(0,pcb,0,0,0,0,2'b01,0,0,0)); rq.push_back(2);
        ret = 1'b1;
      end
      default: ret = 1'b0;
    endcase

    for (int k = 0; k < ew.size(); k++) begin
      rst       = (k == abort_at);
      opcode    = (k == dec_idx) ? op : 7'($urandom);
      funct3    = (k == dec_idx) ? f3 : 3'($urandom);
      zero      = (k == dec_idx + 1 && op == OP_BRANCH) ? z : 1'($urandom);
      mem_ready = (rq[k] == 2) ? 1'($urandom) : rq[k][0];
      exp_w     = (k == abort_at) ? 11'd0 : ew[k];
      @(negedge clk);
      n_cmp++;
      if (cw_a !== exp_w) begin
        n_fail++; $display("FAIL %s cyc%0d ctrl got %b want %b", tag, k, cw_a, exp_w);
      end
      n_cmp++;
      if (cw_b !== exp_w) begin
        n_fail++; $display("FAIL %s cyc%0d ctrl4 got %b want %b", tag, k, cw_b, exp_w);
      end
      n_cmp++;
      if (instret !== 32'(cnt)) begin
        n_fail++; $display("FAIL %s cyc%0d instret got %0d want %0d", tag, k, instret, cnt);
      end
      n_cmp++;
      if (instret_s !== 4'(cnt)) begin
        n_fail++; $display("FAIL %s cyc%0d instret4 got %0d want %0d", tag, k, instret_s, 4'(cnt));
      end
`ifdef ILLEGAL_TRAP_EN
      n_cmp++;
      if (illegal !== 1'b0) begin
        n_fail++; $display("FAIL %s cyc%0d illegal got %b want 0", tag, k, illegal);
      end
`endif
      @(posedge clk); #1;
      if (k == abort_at) begin
        cnt = 0;
        rst = 1'b0;
        return;
      end
      if (ret && k == ew.size() - 1) cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      opcode = 7'($urandom); funct3 = 3'($urandom);
      zero = 1'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (cw_a !== 11'd0 || cw_b !== 11'd0) begin
        n_fail++; $display("FAIL reset ctrl got %b/%b want 0", cw_a, cw_b);
      end
      n_cmp++;
      if (instret !== 32'd0 || instret_s !== 4'd0) begin
        n_fail++; $display("FAIL reset instret got %0d/%0d want 0", instret, instret_s);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    cnt = 0;
  endtask

  task automatic test_rtype();
    run_instr("rtype", OP_R, 3'($urandom), 1'b0, 0, 0, -1);
    n_cmp++;
    if (instret !== 32'd1) begin
      n_fail++; $display("FAIL rtype_retire instret got %0d want 1", instret);
    end
    run_instr("itype", OP_I, 3'($urandom), 1'b0, 1, 0, -1);
  endtask

  task automatic test_load_wait();
    run_instr("load_w2", OP_LOAD, 3'b010, 1'b0, 0, 2, -1);
  endtask

  task automatic test_branches();
    run_instr("beq_z1", OP_BRANCH, F3_BEQ, 1'b1, 0, 0, -1);
    run_instr("bne_z1", OP_BRANCH, F3_BNE, 1'b1, 0, 0, -1);
    run_instr("beq_z0", OP_BRANCH, F3_BEQ, 1'b0, 0, 0, -1);
    run_instr("bne_z0", OP_BRANCH, F3_BNE, 1'b0, 0, 0, -1);
    run_instr("blt",    OP_BRANCH, 3'b100, 1'b1, 0, 0, -1);
  endtask

  task automatic test_store();
    run_instr("store", OP_STORE, 3'b010, 1'b0, 1, 1, -1);
  endtask

  task automatic test_illegal();
    int hold;
    run_instr("illegal", 7'b1111111, 3'($urandom), 1'b0, 0, 0, -1);
`ifdef ILLEGAL_TRAP_EN
    hold = cnt;
    for (int k = 0; k < 10; k++) begin
      opcode = 7'($urandom); funct3 = 3'($urandom);
      zero = 1'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (cw_a !== 11'd0 || illegal !== 1'b1) begin
        n_fail++; $display("FAIL trap cyc%0d ctrl %b illegal %b want 0/1", k, cw_a, illegal);
      end
      n_cmp++;
      if (instret !== 32'(hold) || illegal_s !== 1'b1) begin
        n_fail++; $display("FAIL trap_hold cyc%0d instret %0d want %0d", k, instret, hold);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (illegal !== 1'b0) begin
      n_fail++; $display("FAIL trap_rst illegal got %b want 0", illegal);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
`else
    hold = cnt;
    run_instr("after_illegal", OP_R, 3'd0, 1'b0, 0, 0, -1);
    n_cmp++;
    if (instret !== 32'(hold + 1)) begin
      n_fail++; $display("FAIL nop_uncounted instret got %0d want %0d", instret, hold + 1);
    end
`endif
  endtask

  task automatic test_reset_mid();
    run_instr("store_abort", OP_STORE, 3'b010, 1'b0, 0, 3, 4);
    opcode = 7'($urandom); mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_write !== 1'b0 || mem_read !== 1'b1 || addr_sel !== 1'b0) begin
      n_fail++; $display("FAIL abort_fetch mw %b mr %b as %b want 0 1 0", mem_write, mem_read, addr_sel);
    end
    n_cmp++;
    if (instret !== 32'd0) begin
      n_fail++; $display("FAIL abort_instret got %0d want 0", instret);
    end
    @(posedge clk); #1;
    run_instr("post_abort", OP_LOAD, 3'b010, 1'b0, 0, 0, -1);
  endtask

  task automatic test_wrap();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; cnt = 0;
    for (int i = 0; i < 16; i++)
      run_instr("wrap", OP_BRANCH, 3'($urandom), 1'($urandom), 0, 0, -1);
    n_cmp++;
    if (instret_s !== 4'd0 || instret !== 32'd16) begin
      n_fail++; $display("FAIL wrap instret4 %0d instret %0d want 0 16", instret_s, instret);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    int         n;
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LOAD; ops[3] = OP_STORE; ops[4] = OP_BRANCH;
`ifdef ILLEGAL_TRAP_EN
    ops[5] = OP_R;
    n = 6;
`else
    ops[5] = 7'b0110111;
    n = 6;
`endif
    for (int i = 0; i < 60; i++)
      run_instr("random", ops[$urandom_range(0, n - 1)], 3'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), -1);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branches();
    test_store();
    test_illegal();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Multi-cycle control sequencer for the RV32I core. Replaces single-cycle decode with a state machine that steps the shared ALU, register file and single unified memory port through fetch, decode, execute, memory and write-back phases. Stalls on a memory-ready handshake and counts retired instructions. Sits between the instruction register and the datapath muxes/enables.

## Interface
- `INSTRET_W`, 32: width of the retired-instruction counter.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: instruction-register opcode field [6:0].
- `funct3` in 3: instruction-register funct3 field.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory port completed the current access this cycle.
- `pc_write` out 1: load PC+4 into PC.
- `pc_branch` out 1: load branch target into PC.
- `ir_write` out 1: load instruction register from memory read data.
- `addr_sel` out 1: memory address select; 0 = PC, 1 = ALU result register.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `alu_op` out 2: 00 add, 01 subtract (branch compare), 10 R-type funct decode, 11 I-type funct decode.
- `alu_src` out 1: 0 = rs2, 1 = immediate.
- `reg_write` out 1: register-file write enable.
- `mem_to_reg` out 1: write-back select; 0 = ALU, 1 = memory data.
- `illegal_instr` out 1: unsupported opcode trapped. Present only with the macro.
- `instret` out INSTRET_W: retired-instruction count.

## Operation
- State register values: FETCH, DECODE, EXEC_ALU, EXEC_ADDR, EXEC_BR, MEM, WB_ALU, WB_LOAD, TRAP.
- The opcode is latched into `op_q` and funct3 into `f3_q` in DECODE. Later states use only the latched copies.
- FETCH:
  - Outputs: `addr_sel`=0, `mem_read`=1.
  - Stays in FETCH while `mem_ready`=0.
  - On `mem_ready`=1: `ir_write`=1 and `pc_write`=1 in that same cycle, then go to DECODE.
- DECODE: no enables asserted. Next state by opcode:
  - 0110011 or 0010011 → EXEC_ALU.
  - 0000011 or 0100011 → EXEC_ADDR.
  - 1100011 → EXEC_BR.
  - Any other opcode → TRAP with the macro, else FETCH without it.
- EXEC_ALU: `alu_op` is 10 for R-type (`alu_src`=0) or 11 for I-type (`alu_src`=1). Next state WB_ALU.
- WB_ALU: `reg_write`=1, `mem_to_reg`=0, retire. Next state FETCH.
- EXEC_ADDR: `alu_op`=00, `alu_src`=1. Next state MEM.
- MEM:
  - `addr_sel`=1; `mem_read`=1 for a load, `mem_write`=1 for a store.
  - Stays in MEM while `mem_ready`=0.
  - On `mem_ready`=1: a load goes to WB_LOAD; a store retires and goes to FETCH.
- WB_LOAD: `reg_write`=1, `mem_to_reg`=1, retire. Next state FETCH.
- EXEC_BR:
  - `alu_op`=01, `alu_src`=0.
  - `pc_branch` = `zero` when `f3_q`=000 and `~zero` when `f3_q`=001; 0 for any other funct3.
  - Retire. Next state FETCH.
- Control outputs:
  - All outputs are Moore, decoded from state, except the FETCH and MEM completion pulses, which are qualified by `mem_ready`.
  - Every unlisted output in a state is 0.
- Retire: `instret` increments by 1 and wraps modulo 2^INSTRET_W; there is no saturation.

## Timing
- Reset:
  - `rst`=1 at a rising edge sets state to FETCH, `instret` to 0, `op_q`/`f3_q` to 0, and clears TRAP.
  - Every control output is 0 while `rst` is high.
- Latency with zero-wait memory (`mem_ready` high on first request cycle):
  - R-type and I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each cycle of `mem_ready`=0 in FETCH or MEM adds exactly one cycle.
- `mem_read` and `mem_write` stay asserted continuously until the `mem_ready` cycle. They drop in the cycle after it.
- `mem_ready` is ignored in every state except FETCH and MEM.
- Reset asserted mid-instruction, including during a memory wait, aborts the instruction: no retire, no write enables, next state FETCH.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - Unsupported opcodes enter TRAP.
  - TRAP holds all enables at 0 and `illegal_instr`=1 until reset; `instret` is frozen.
- `ILLEGAL_TRAP_EN` undefined:
  - Unsupported opcodes return to FETCH with no retire, i.e. they behave as an uncounted NOP.
  - The `illegal_instr` port and the TRAP state do not exist.

## Structure
- Shared package `rv_ctrl_pkg`:
  - State enum.
  - Opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH.
  - ALU-op constants: ALUOP_ADD, ALUOP_SUB, ALUOP_R, ALUOP_I.
  - funct3 constants: F3_BEQ, F3_BNE.
- One sub-module, `instret_counter`: parameterised-width counter with synchronous clear and increment enable.

## Test plan
- Zero-wait R-type (opcode 0110011) after reset:
  - FETCH/DECODE/EXEC_ALU/WB_ALU over 4 cycles.
  - `alu_op`=10 in cycle 3, `reg_write` in cycle 4.
  - `instret` goes 0→1.
- Load with `mem_ready` low for 2 cycles in MEM:
  - Total 7 cycles.
  - `mem_read` and `addr_sel`=1 held for 3 MEM cycles.
  - WB_LOAD asserts `mem_to_reg`=1 with `reg_write`=1.
- Branches:
  - BEQ with `zero`=1 → `pc_branch`=1.
  - BNE with `zero`=1 → `pc_branch`=0.
  - Each takes 3 cycles and `instret` increments.
- Store: `mem_write`=1 only in MEM, `reg_write` never set, `instret` increments when `mem_ready` rises.
- Opcode 1111111:
  - With `ILLEGAL_TRAP_EN`: TRAP, `illegal_instr`=1, outputs 0 for 10 cycles, `instret` unchanged.
  - Without it: returns to FETCH in cycle 3, no retire.
- `rst` pulsed during a MEM wait of a store: no `mem_write` after reset, state FETCH, `instret`=0.
- INSTRET_W=4 with 16 retires: `instret` wraps to 0.
